// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   sb_entry_t  : one scoreboard slot that shadows a datapath pipeline register
//   ctl_mode_e  : the control decision chosen for the current cycle
//   FWD_NONE    : forwarding select value meaning "take the register file value"
//   SB_RF_W     : widest register index the scoreboard holds; narrower indices
//                 are zero-extended into it, so equality compares are unaffected
package Pipe_Buf_Reg_PKG;

  localparam int SB_RF_W  = 8;
  localparam int FWD_NONE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RF_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic               halt;
    logic [SB_RF_W-1:0] rs1;
    logic [SB_RF_W-1:0] rs2;
  } sb_entry_t;

  // Listed in priority order, highest first.
  typedef enum logic [2:0] {
    CTL_RESET,
    CTL_HALTED,
    CTL_MEM_WAIT,
    CTL_EX_BUSY,
    CTL_REDIRECT,
    CTL_HALT_DRAIN,
    CTL_LOAD_USE,
    CTL_RUN
  } ctl_mode_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
//   master : datapath side, drives ID decode fields and EX/MEM status
//   slave  : controller side, drives enables, flushes, forwarding selects,
//            halted flag and stall counter
interface pipe_hazard_ctrl_if #(
  parameter int NUM_PREGS  = 4,
  parameter int RF_ADDRESS = 5,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(NUM_PREGS + 1)
);
  logic                  id_valid;
  logic [RF_ADDRESS-1:0] id_rs1;
  logic [RF_ADDRESS-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [RF_ADDRESS-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_halt;
  logic                  ex_busy;
  logic                  mem_wait;
  logic                  redirect;
  logic [NUM_PREGS:0]    reg_en;
  logic [NUM_PREGS-1:0]  reg_flush;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;
  logic                  halted;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, id_halt, ex_busy, mem_wait, redirect,
    input  reg_en, reg_flush, fwd_a, fwd_b, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, id_halt, ex_busy, mem_wait, redirect,
    output reg_en, reg_flush, fwd_a, fwd_b, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Combinational forwarding source search for one EX operand.
//   rs_i   : source register of the instruction now in EX
//   cand_i : bit k set when pipeline register k holds a forwardable result
//   rd_i   : destination register held in each pipeline register
//   sel_o  : lowest (youngest) matching k, or FWD_NONE
module pipe_fwd_select
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int NUM_PREGS = 4,
  parameter int FWD_W     = $clog2(NUM_PREGS + 1)
) (
  input  logic [SB_RF_W-1:0] rs_i,
  input  logic [NUM_PREGS:3] cand_i,
  input  logic [SB_RF_W-1:0] rd_i [3:NUM_PREGS],
  output logic [FWD_W-1:0]   sel_o
);

  // Scan oldest to youngest so the youngest hit is the one left standing.
  always_comb begin
    sel_o = FWD_W'(FWD_NONE);
    for (int k = NUM_PREGS; k >= 3; k--) begin
      if (cand_i[k] && (rd_i[k] == rs_i)) begin
        sel_o = FWD_W'(k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight destinations for
// pipeline registers 2..NUM_PREGS, producing PC/pipeline-register enables,
// bubble flushes, EX forwarding selects, a sticky halt flag and a saturating
// stall counter.
//   clk   : clock
//   reset : synchronous, active low
//   bus   : pipe_hazard_ctrl_if.slave (ID decode in, control out)
module pipe_hazard_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int NUM_PREGS  = 4,
  parameter int RF_ADDRESS = 5,
  parameter int LOAD_READY = 4,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = $clog2(NUM_PREGS + 1)
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  sb_entry_t             sb_q [2:NUM_PREGS];
  sb_entry_t             sb_d [2:NUM_PREGS];
  sb_entry_t             id_entry;
  logic                  halted_q, halted_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [RF_ADDRESS-1:0] id_rd, id_rs1, id_rs2;
  logic                  rs1_live, rs2_live, load_use;
  logic [NUM_PREGS:2]    lu_hit;
  logic [NUM_PREGS:3]    fwd_cand;
  logic [SB_RF_W-1:0]    fwd_rd [3:NUM_PREGS];
  logic [FWD_W-1:0]      fwd_a_raw, fwd_b_raw;
  ctl_mode_e             mode;
  logic [NUM_PREGS:0]    reg_en;
  logic [NUM_PREGS-1:0]  reg_flush;

  assign id_rd  = bus.id_rd;
  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = bus.id_valid;
    id_entry.rd        = SB_RF_W'(id_rd);
    id_entry.reg_write = bus.id_reg_write;
    id_entry.mem_read  = bus.id_mem_read;
    id_entry.halt      = bus.id_halt;
    id_entry.rs1       = SB_RF_W'(id_rs1);
    id_entry.rs2       = SB_RF_W'(id_rs2);
  end

  // x0 is never a real dependency, so a zero source cannot cause a stall.
  assign rs1_live = bus.id_valid && bus.id_rs1_used && (id_rs1 != '0);
  assign rs2_live = bus.id_valid && bus.id_rs2_used && (id_rs2 != '0);

  // Loads still too young to forward by the time the consumer reaches EX.
  for (genvar gi = 2; gi <= NUM_PREGS; gi++) begin : g_lu
    if (gi <= LOAD_READY - 2) begin : g_chk
      assign lu_hit[gi] = sb_q[gi].valid && sb_q[gi].mem_read &&
                          ((rs1_live && (sb_q[gi].rd == id_entry.rs1)) ||
                           (rs2_live && (sb_q[gi].rd == id_entry.rs2)));
    end else begin : g_none
      assign lu_hit[gi] = 1'b0;
    end
  end
  assign load_use = |lu_hit;

  // A load result only becomes a forwarding source once it reaches LOAD_READY.
  for (genvar gi = 3; gi <= NUM_PREGS; gi++) begin : g_cand
    assign fwd_cand[gi] = sb_q[gi].valid && sb_q[gi].reg_write &&
                          (sb_q[gi].rd != '0) &&
                          !(sb_q[gi].mem_read && (gi < LOAD_READY));
    assign fwd_rd[gi]   = sb_q[gi].rd;
  end

  pipe_fwd_select #(.NUM_PREGS(NUM_PREGS), .FWD_W(FWD_W)) u_fwd_a (
    .rs_i(sb_q[2].rs1), .cand_i(fwd_cand), .rd_i(fwd_rd), .sel_o(fwd_a_raw)
  );

  pipe_fwd_select #(.NUM_PREGS(NUM_PREGS), .FWD_W(FWD_W)) u_fwd_b (
    .rs_i(sb_q[2].rs2), .cand_i(fwd_cand), .rd_i(fwd_rd), .sel_o(fwd_b_raw)
  );

  always_comb begin
    if (!reset)                          mode = CTL_RESET;
    else if (halted_q)                   mode = CTL_HALTED;
    else if (bus.mem_wait)               mode = CTL_MEM_WAIT;
    else if (bus.ex_busy)                mode = CTL_EX_BUSY;
    else if (bus.redirect)               mode = CTL_REDIRECT;
    else if (sb_q[2].valid && sb_q[2].halt) mode = CTL_HALT_DRAIN;
    else if (load_use)                   mode = CTL_LOAD_USE;
    else                                 mode = CTL_RUN;
  end

  always_comb begin
    reg_en    = '1;
    reg_flush = '0;
    case (mode)
      CTL_RESET: begin
        reg_en    = '0;
        reg_flush = '1;
      end
      CTL_HALTED, CTL_MEM_WAIT: reg_en = '0;
      CTL_EX_BUSY: begin
        // EX holds its instruction; EX/MEM gets a bubble, later stages drain.
        reg_en[2:0]  = 3'b000;
        reg_flush[2] = 1'b1;
      end
      CTL_REDIRECT:   reg_flush[1:0] = 2'b11;
      CTL_HALT_DRAIN: begin
        // Stop fetching past the halt; everything older keeps moving.
        reg_en[0]    = 1'b0;
        reg_flush[0] = 1'b1;
      end
      CTL_LOAD_USE: begin
        reg_en[1:0]  = 2'b00;
        reg_flush[1] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sb_d = sb_q;
    if (reg_flush[1])   sb_d[2] = '0;
    else if (reg_en[2]) sb_d[2] = id_entry;
    for (int k = 3; k <= NUM_PREGS; k++) begin
      if (reg_flush[k-1])  sb_d[k] = '0;
      else if (reg_en[k])  sb_d[k] = sb_q[k-1];
    end

    halted_d = halted_q ||
               (sb_q[NUM_PREGS].valid && sb_q[NUM_PREGS].halt && reg_en[NUM_PREGS]);

    stall_cnt_d = stall_cnt_q;
    if (!reg_en[0] && !halted_q && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 2; k <= NUM_PREGS; k++) sb_q[k] <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.reg_en    = reg_en;
  assign bus.reg_flush = reg_flush;
  assign bus.fwd_a     = (mode == CTL_RESET) ? FWD_W'(FWD_NONE) : fwd_a_raw;
  assign bus.fwd_b     = (mode == CTL_RESET) ? FWD_W'(FWD_NONE) : fwd_b_raw;
  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline control unit for the RISC-V core: tracks in-flight destination registers across all pipeline registers. From that scoreboard it generates the PC and pipeline-register enables and flushes, plus the EX-operand forwarding selects. It generalises the current 5-stage hazard, forward and flush logic to configurable depth and load-ready stage. It adds a variable-latency EX handshake, a data-memory wait, halt draining and a stall performance counter. It sits beside the datapath: ID-stage decode fields in, register enables, flushes and forwarding selects out.

## Interface
- NUM_PREGS, 4, number of pipeline registers (1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, … NUM_PREGS = last before WB); minimum 4
- RF_ADDRESS, 5, register index width
- LOAD_READY, 4, first pipeline register whose load result is forwardable; range 3..NUM_PREGS
- CNT_W, 16, stall counter width
- FWD_W, $clog2(NUM_PREGS+1), forwarding select width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1, id_rs2  in  RF_ADDRESS  ID source registers
- id_rs1_used, id_rs2_used  in  1  source is actually read
- id_rd  in  RF_ADDRESS  ID destination
- id_reg_write, id_mem_read, id_halt  in  1  ID decode flags
- ex_busy  in  1  multi-cycle EX unit not finished
- mem_wait  in  1  data memory not ready
- redirect  in  1  taken branch/jump resolved in EX (PcSel)
- reg_en  out  NUM_PREGS+1  bit 0 = PC, bit k = pipeline register k load enable
- reg_flush  out  NUM_PREGS  bit k-1 = load bubble into register k (wins over reg_en)
- fwd_a, fwd_b  out  FWD_W  EX operand source: 0 = register file value, k = pipeline register k
- halted  out  1  sticky, halt instruction retired
- stall_cnt  out  CNT_W  saturating stall-cycle count

## Operation
- Scoreboard entry per register 2..NUM_PREGS: {valid, rd, reg_write, mem_read, halt, rs1, rs2}. Register 2 loads the ID fields, or a bubble when flushed. Entry k loads entry k-1 when reg_en[k] is set. Entries hold when reg_en[k] is clear. Flush sets valid=0.
- Forwarding (EX, from entry 2 rs1/rs2): search k = 3..NUM_PREGS, lowest k first. A hit needs valid, reg_write, rd == rs, rd != 0, and not (mem_read and k < LOAD_READY). No hit gives 0.
- Load-use: stall when an ID source (used, id_valid, rs != 0) matches entry k with valid, mem_read and rd, for 2 ≤ k ≤ LOAD_READY-2. Action: reg_en[1:0]=0, reg_flush[1]=1 (bubble into ID/EX), later registers advance.
- Priority, highest first. Each bullet applies only when none above it applies.
  - halted: all reg_en=0, no flush.
  - mem_wait: all reg_en=0, no flush, redirect ignored.
  - ex_busy: reg_en[2:0]=0, reg_flush[2]=1 (bubble into EX/MEM), registers ≥4 advance, redirect ignored.
  - redirect: all reg_en=1, reg_flush[0]=reg_flush[1]=1.
  - halt in entry 2: reg_en[0]=0, reg_flush[0]=1, older stages advance.
  - load-use: as described under Load-use above.
  - Otherwise: all reg_en=1, no flush.
- halted sets on the edge where a valid halt entry leaves register NUM_PREGS. It stays set until reset.
- stall_cnt increments each cycle with reg_en[0]=0 and halted=0. It saturates at all-ones.

## Timing
- While reset is low, at the edge: scoreboard cleared, halted=0, stall_cnt=0. Outputs while reset is low: reg_en=0, reg_flush=all 1, fwd_a=fwd_b=0.
- reg_en, reg_flush and fwd are combinational from scoreboard and inputs: zero-cycle decision latency. State updates on posedge clk.
- Load-use stalls exactly LOAD_READY-1-k cycles (1 for default).
- Simultaneous redirect and load-use: redirect wins, no stall cycle counted.
- Redirect during ex_busy or mem_wait: held off. The branch unit keeps redirect asserted until EX advances.
- Reset low mid-stall or mid-busy: state cleared next edge regardless of other inputs.

## Structure
- Scoreboard entry typedef and the FWD_NONE=0 constant go in Pipe_Buf_Reg_PKG.
- One sub-module: pipe_fwd_select, a combinational youngest-match search instantiated once per operand.

## Test plan
- add x5,x1,x2; sub x6,x5,x3; or x7,x5,x4 → sub in EX: fwd_a=3; or in EX: fwd_a=4; no stall; stall_cnt=0.
- lw x6,0(x1); add x7,x6,x2 → one cycle reg_en[1:0]=0, reg_flush[1]=1; next cycle fwd_a=4; stall_cnt=1.
- Load-use pending and redirect=1 same cycle → reg_flush[1:0]=2'b11, reg_en all 1, stall_cnt unchanged.
- ex_busy=1 for 3 cycles with redirect=1 throughout → reg_en[2:0]=0 and reg_flush[2]=1 for 3 cycles, redirect acted on only in the 4th cycle.
- mem_wait=1 for 2 cycles → reg_en=0, reg_flush=0, scoreboard unchanged. Then the halt op drains → halted=1 the cycle after it leaves register 4; all reg_en=0 thereafter.
- add x0,x1,x2; sub x3,x0,x4 → fwd_a=0. lw x0 followed by use of x0 → no stall.
- reset low during a load-use stall → next cycle reg_flush=all 1, stall_cnt=0, halted=0.
